// File: rtl/dm_abstract_cmd_if.sv
// Abstract-command bundle between the DMI register file, the sequencer and the hart-side debug ROM.
// The slave view belongs to the sequencer; the master view drives commands and hart status.
`timescale 1ns/1ps
interface dm_abstract_cmd_if;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic [2:0]  cmderr_clr;
    logic        hart_halted;
    logic        hart_going;
    logic        hart_done;
    logic        hart_exception;
    logic        go;
    logic [9:0]  entry_addr;
    logic [11:0] fix_reg;
    logic [1:0]  fix_size;
    logic        busy;
    logic [2:0]  cmderr;

    modport slave (
        input  cmd_valid, cmd_data, cmderr_clr,
        input  hart_halted, hart_going, hart_done, hart_exception,
        output go, entry_addr, fix_reg, fix_size, busy, cmderr
    );

    modport master (
        output cmd_valid, cmd_data, cmderr_clr,
        output hart_halted, hart_going, hart_done, hart_exception,
        input  go, entry_addr, fix_reg, fix_size, busy, cmderr
    );
endinterface

// File: rtl/dm_abstract_cmd.sv
// Abstract-command sequencer: validates a DMI command, selects the debug-ROM routine and patch
// values, then runs the go/going/done handshake with the parked hart.
`timescale 1ns/1ps
module dm_abstract_cmd #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    dm_abstract_cmd_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT} state_t;

    state_t           r_state;
    logic             r_go;
    logic             r_busy;
    logic [2:0]       r_cmderr;
    logic [9:0]       r_entry;
    logic [11:0]      r_fix_reg;
    logic [1:0]       r_fix_size;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       w_cmdtype;
    logic [2:0]       w_size;
    logic             w_postexec;
    logic             w_transfer;
    logic             w_write;
    logic [15:0]      w_regno;
    logic             w_is_reg;
    logic             w_is_mem;
    logic             w_is_csr;
    logic             w_is_gpr;
    logic             w_bad_cmd;
    logic             w_noop;
    logic [9:0]       w_entry;
    logic [11:0]      w_fix_reg;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic             w_unused;

    assign w_cmdtype  = bus.cmd_data[31:24];
    assign w_size     = bus.cmd_data[22:20];
    assign w_postexec = bus.cmd_data[18];
    assign w_transfer = bus.cmd_data[17];
    assign w_write    = bus.cmd_data[16];
    assign w_regno    = bus.cmd_data[15:0];
    assign w_unused   = ^{bus.cmd_data[23], bus.cmd_data[19]};

    assign w_is_reg  = (w_cmdtype == 8'd0);
    assign w_is_mem  = (w_cmdtype == 8'd2);
    assign w_is_csr  = (w_regno[15:12] == 4'h0);
    assign w_is_gpr  = (w_regno[15:5] == 11'h080);
    assign w_bad_cmd = !(w_is_reg || w_is_mem) || w_postexec
                     || (w_is_reg && (w_size != 3'd2))
                     || (w_is_mem && (w_size > 3'd2))
                     || (w_is_reg && w_transfer && !(w_is_csr || w_is_gpr));
    // A register access without transfer has nothing to run on the hart.
    assign w_noop    = w_is_reg && !w_transfer;

    always_comb begin
        w_entry   = 10'h000;
        w_fix_reg = 12'h000;
        if (w_is_mem) begin
            w_entry = w_write ? 10'h1DC : 10'h1F8;
        end else if (w_is_gpr) begin
            w_fix_reg = {7'b0, w_regno[4:0]};
            if (w_regno[4:0] == 5'd8)
                w_entry = w_write ? 10'h100 : 10'h13C;
            else if (w_regno[4:0] == 5'd9)
                w_entry = w_write ? 10'h114 : 10'h150;
            else
                w_entry = w_write ? 10'h128 : 10'h160;
        end else begin
            w_fix_reg = w_regno[11:0];
            if (w_regno[11:0] == 12'h7B1)
                w_entry = w_write ? 10'h170 : 10'h1A8;
            else
                w_entry = w_write ? 10'h184 : 10'h1B8;
        end
    end

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc >= CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_go       <= 1'b0;
            r_busy     <= 1'b0;
            r_cmderr   <= 3'd0;
            r_entry    <= 10'h000;
            r_fix_reg  <= 12'h000;
            r_fix_size <= 2'd0;
            r_cnt      <= '0;
        end else begin
            // Any error raised below overrides this clear, so a set always wins.
            r_cmderr <= r_cmderr & ~bus.cmderr_clr;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && (r_cmderr == 3'd0)) begin
                        if (w_bad_cmd) begin
                            r_cmderr <= 3'd2;
                        end else if (!bus.hart_halted) begin
                            r_cmderr <= 3'd4;
                        end else if (!w_noop) begin
                            r_state    <= S_GO;
                            r_go       <= 1'b1;
                            r_busy     <= 1'b1;
                            r_cnt      <= '0;
                            r_entry    <= w_entry;
                            r_fix_reg  <= w_fix_reg;
                            r_fix_size <= w_size[1:0];
                        end
                    end
                end
                S_GO, S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (!bus.hart_halted) begin
                        r_state  <= S_IDLE;
                        r_go     <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cmderr <= 3'd4;
                    end else if (bus.hart_exception) begin
                        r_state  <= S_IDLE;
                        r_go     <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cmderr <= 3'd3;
                    end else if (bus.hart_done) begin
                        r_state <= S_IDLE;
                        r_go    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_go     <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cmderr <= 3'd7;
                    end else if ((r_state == S_GO) && bus.hart_going) begin
                        r_state <= S_WAIT;
                        r_go    <= 1'b0;
                    end
                    if (bus.cmd_valid) begin
                        r_cmderr <= 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.go         = r_go;
    assign bus.busy       = r_busy;
    assign bus.cmderr     = r_cmderr;
    assign bus.entry_addr = r_entry;
    assign bus.fix_reg    = r_fix_reg;
    assign bus.fix_size   = r_fix_size;
endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Directed bench for dm_abstract_cmd with a command-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_dm_abstract_cmd;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_abstract_cmd_if bus();

    dm_abstract_cmd #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic        m_busy = 1'b0;
    logic        m_go = 1'b0;
    logic [2:0]  m_cmderr = 3'd0;
    logic [9:0]  m_entry = 10'h0;
    logic [11:0] m_freg = 12'h0;
    logic [1:0]  m_fsize = 2'd0;
    int          m_age = 0;
    logic        m_set;
    logic [2:0]  m_code;
    logic [2:0]  m_e;

    logic [31:0] bad_cmds [5] = '{32'h0122_1005, 32'h0026_1005, 32'h0032_1005,
                                  32'h0230_0000, 32'h0022_1020};

    // Command acceptance outcome: 0 = runnable or no-op, otherwise the cmderr code.
    function automatic logic [2:0] err_of(input logic [31:0] c, input logic halted);
        logic [7:0]  t;
        logic [2:0]  sz;
        logic [15:0] rn;
        t  = c[31:24];
        sz = c[22:20];
        rn = c[15:0];
        if (t != 8'd0 && t != 8'd2) return 3'd2;
        if (c[18]) return 3'd2;
        if (t == 8'd0 && sz != 3'd2) return 3'd2;
        if (t == 8'd2 && sz > 3'd2) return 3'd2;
        if (t == 8'd0 && c[17] && rn > 16'h101F) return 3'd2;
        if (!halted) return 3'd4;
        return 3'd0;
    endfunction

    // Returns {entry_addr, fix_reg, fix_size} for a runnable command.
    function automatic logic [23:0] decode(input logic [31:0] c);
        logic [15:0] rn;
        logic        w;
        logic [9:0]  ea;
        logic [11:0] fr;
        rn = c[15:0];
        w  = c[16];
        fr = 12'h0;
        if (c[31:24] == 8'd2) begin
            ea = w ? 10'h1DC : 10'h1F8;
        end else if (rn >= 16'h1000) begin
            fr = 12'(rn - 16'h1000);
            if (rn == 16'h1008)      ea = w ? 10'h100 : 10'h13C;
            else if (rn == 16'h1009) ea = w ? 10'h114 : 10'h150;
            else                     ea = w ? 10'h128 : 10'h160;
        end else begin
            fr = rn[11:0];
            ea = (rn == 16'h07B1) ? (w ? 10'h170 : 10'h1A8) : (w ? 10'h184 : 10'h1B8);
        end
        return {ea, fr, c[21:20]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_go = 1'b0; m_cmderr = 3'd0;
            m_entry = 10'h0; m_freg = 12'h0; m_fsize = 2'd0; m_age = 0;
        end else begin
            m_set  = 1'b0;
            m_code = 3'd0;
            if (m_busy) begin
                m_age = m_age + 1;
                if (!bus.hart_halted) begin
                    m_busy = 1'b0; m_go = 1'b0; m_set = 1'b1; m_code = 3'd4;
                end else if (bus.hart_exception) begin
                    m_busy = 1'b0; m_go = 1'b0; m_set = 1'b1; m_code = 3'd3;
                end else if (bus.hart_done) begin
                    m_busy = 1'b0; m_go = 1'b0;
                end else if (m_age >= TO) begin
                    m_busy = 1'b0; m_go = 1'b0; m_set = 1'b1; m_code = 3'd7;
                end else if (bus.hart_going) begin
                    m_go = 1'b0;
                end
                if (bus.cmd_valid) begin
                    m_set = 1'b1; m_code = 3'd1;
                end
            end else if (bus.cmd_valid && m_cmderr == 3'd0) begin
                m_e = err_of(bus.cmd_data, bus.hart_halted);
                if (m_e != 3'd0) begin
                    m_set = 1'b1; m_code = m_e;
                end else if (!(bus.cmd_data[31:24] == 8'd0 && !bus.cmd_data[17])) begin
                    {m_entry, m_freg, m_fsize} = decode(bus.cmd_data);
                    m_busy = 1'b1; m_go = 1'b1; m_age = 0;
                end
            end
            m_cmderr = m_set ? m_code : (m_cmderr & ~bus.cmderr_clr);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({bus.go, bus.busy, bus.cmderr, bus.entry_addr, bus.fix_reg, bus.fix_size}
                !== {m_go, m_busy, m_cmderr, m_entry, m_freg, m_fsize}) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t actual go=%b busy=%b cmderr=%0d entry=%h freg=%h fsize=%0d required go=%b busy=%b cmderr=%0d entry=%h freg=%h fsize=%0d",
                         $time, bus.go, bus.busy, bus.cmderr, bus.entry_addr, bus.fix_reg, bus.fix_size,
                         m_go, m_busy, m_cmderr, m_entry, m_freg, m_fsize);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] c);
        bus.cmd_data  = c;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic hart(input logic g, input logic d, input logic e);
        bus.hart_going     = g;
        bus.hart_done      = d;
        bus.hart_exception = e;
        tick();
        bus.hart_going     = 1'b0;
        bus.hart_done      = 1'b0;
        bus.hart_exception = 1'b0;
    endtask

    task automatic clr(input logic [2:0] m);
        bus.cmderr_clr = m;
        tick();
        bus.cmderr_clr = 3'd0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_data = 32'h0; bus.cmderr_clr = 3'd0;
        bus.hart_halted = 1'b1; bus.hart_going = 1'b0; bus.hart_done = 1'b0;
        bus.hart_exception = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_go", 32'(bus.go), 32'h0);
        check("rst_cmderr", 32'(bus.cmderr), 32'h0);

        // GPR x5 read, word
        issue(32'h0022_1005);
        check("gpr_entry", 32'(bus.entry_addr), 32'h160);
        check("gpr_fix_reg", 32'(bus.fix_reg), 32'h5);
        check("gpr_fix_size", 32'(bus.fix_size), 32'h2);
        check("gpr_go", 32'(bus.go), 32'h1);
        check("gpr_busy", 32'(bus.busy), 32'h1);
        hart(1'b1, 1'b0, 1'b0);
        check("going_go", 32'(bus.go), 32'h0);
        check("going_busy", 32'(bus.busy), 32'h1);
        tick();
        hart(1'b0, 1'b1, 1'b0);
        check("done_busy", 32'(bus.busy), 32'h0);
        check("done_cmderr", 32'(bus.cmderr), 32'h0);

        // write s0
        issue(32'h0023_1008);
        check("s0_entry", 32'(bus.entry_addr), 32'h100);
        check("s0_fix_reg", 32'(bus.fix_reg), 32'h8);
        hart(1'b1, 1'b0, 1'b0);
        hart(1'b0, 1'b1, 1'b0);

        // write dpc, completed by done while still in GO
        issue(32'h0023_07B1);
        check("dpc_entry", 32'(bus.entry_addr), 32'h170);
        check("dpc_fix_reg", 32'(bus.fix_reg), 32'h7B1);
        hart(1'b0, 1'b1, 1'b0);
        check("done_in_go_busy", 32'(bus.busy), 32'h0);

        // memory read, halfword
        issue(32'h0210_0000);
        check("mem_entry", 32'(bus.entry_addr), 32'h1F8);
        check("mem_fix_size", 32'(bus.fix_size), 32'h1);
        check("mem_fix_reg", 32'(bus.fix_reg), 32'h0);
        hart(1'b1, 1'b0, 1'b0);
        hart(1'b0, 1'b1, 1'b0);

        // unsupported encodings
        for (int i = 0; i < 5; i++) begin
            issue(bad_cmds[i]);
            check($sformatf("bad%0d_cmderr", i), 32'(bus.cmderr), 32'h2);
            check($sformatf("bad%0d_busy", i), 32'(bus.busy), 32'h0);
            if (i == 0) begin
                issue(32'h0022_1005);
                check("ignored_busy", 32'(bus.busy), 32'h0);
                check("ignored_cmderr", 32'(bus.cmderr), 32'h2);
            end
            clr(3'd7);
            check($sformatf("bad%0d_clr", i), 32'(bus.cmderr), 32'h0);
        end

        // not halted
        bus.hart_halted = 1'b0;
        issue(32'h0022_1005);
        check("nohalt_cmderr", 32'(bus.cmderr), 32'h4);
        check("nohalt_busy", 32'(bus.busy), 32'h0);
        bus.hart_halted = 1'b1;
        clr(3'd7);

        // second command while busy
        issue(32'h0022_1005);
        issue(32'h0023_1009);
        check("busy_err_cmderr", 32'(bus.cmderr), 32'h1);
        check("busy_err_busy", 32'(bus.busy), 32'h1);
        check("busy_err_entry", 32'(bus.entry_addr), 32'h160);
        hart(1'b1, 1'b0, 1'b0);
        hart(1'b0, 1'b1, 1'b0);
        check("busy_err_done", 32'(bus.busy), 32'h0);
        check("busy_err_kept", 32'(bus.cmderr), 32'h1);
        clr(3'd7);

        // exception and done together, with a simultaneous clear
        issue(32'h0022_1005);
        hart(1'b1, 1'b0, 1'b0);
        bus.cmderr_clr = 3'd7;
        hart(1'b0, 1'b1, 1'b1);
        bus.cmderr_clr = 3'd0;
        check("exc_cmderr", 32'(bus.cmderr), 32'h3);
        check("exc_busy", 32'(bus.busy), 32'h0);
        clr(3'd7);

        // timeout with a silent hart
        issue(32'h0022_1005);
        repeat (TO - 1) tick();
        check("to_still_busy", 32'(bus.busy), 32'h1);
        tick();
        check("to_busy", 32'(bus.busy), 32'h0);
        check("to_go", 32'(bus.go), 32'h0);
        check("to_cmderr", 32'(bus.cmderr), 32'h7);
        clr(3'd7);

        // reset in WAIT
        issue(32'h0023_1008);
        hart(1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs",
              32'({bus.go, bus.busy, bus.cmderr, bus.entry_addr, bus.fix_reg, bus.fix_size}), 32'h0);

        // halt lost during GO
        issue(32'h0022_1005);
        bus.hart_halted = 1'b0;
        tick();
        bus.hart_halted = 1'b1;
        check("halt_lost_cmderr", 32'(bus.cmderr), 32'h4);
        check("halt_lost_go", 32'(bus.go), 32'h0);
        check("halt_lost_busy", 32'(bus.busy), 32'h0);
        clr(3'd7);

        // register access without transfer
        issue(32'h0020_1005);
        check("noop_busy", 32'(bus.busy), 32'h0);
        check("noop_go", 32'(bus.go), 32'h0);
        check("noop_cmderr", 32'(bus.cmderr), 32'h0);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
